// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - register map, bit positions and FSM states for the LED pattern sequencer
package led_seq_pkg;

  localparam logic [2:0] ADDR_CTRL         = 3'd0;
  localparam logic [2:0] ADDR_PERIOD       = 3'd1;
  localparam logic [2:0] ADDR_STATUS       = 3'd2;
  localparam logic [2:0] ADDR_PATTERN_BASE = 3'd4;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_LOOP     = 1;
  localparam int CTRL_LAST_LSB = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_IDX_LSB = 4;
  localparam int STAT_DONE    = 8;

  localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/led_seq_if.sv
// rtl/led_seq_if.sv - CPU-side register slave bus and PIO-side master bus of the sequencer
interface led_seq_if;

  logic [2:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;

  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  modport slave (
    input  s_address, s_chipselect, s_write_n, s_writedata,
    output s_readdata,
    output m_address, m_chipselect, m_write_n, m_writedata
  );

  modport master (
    output s_address, s_chipselect, s_write_n, s_writedata,
    input  s_readdata,
    input  m_address, m_chipselect, m_write_n, m_writedata
  );

endinterface

// File: rtl/led_seq_timer.sv
// rtl/led_seq_timer.sv - loadable down-counter that paces the steps between PIO writes
module led_seq_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] load_value,
  output logic                zero
);

  logic [PERIOD_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - PERIOD_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - steps up to four LED patterns out to the PIO data register
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int                  LED_W          = 10,
  parameter int                  PERIOD_W       = 32,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(50000000)
) (
  input  logic     clk,
  input  logic     reset_n,
  led_seq_if.slave bus
);

  state_t              state, next_state;
  logic [1:0]          idx, idx_next;
  logic                ctrl_loop;
  logic [1:0]          ctrl_last;
  logic [PERIOD_W-1:0] period;
  logic [LED_W-1:0]    pattern [4];
  logic                done;

  logic wr, wr_ctrl, wr_period, wr_status, wr_pat, run_bit, busy, abort;
  logic tmr_load, tmr_zero, done_set;
  logic m_cs, m_wn;
  logic [31:0] m_wd, rdata;

  assign wr        = bus.s_chipselect && !bus.s_write_n;
  assign wr_ctrl   = wr && (bus.s_address == ADDR_CTRL);
  assign wr_period = wr && (bus.s_address == ADDR_PERIOD);
  assign wr_status = wr && (bus.s_address == ADDR_STATUS);
  assign wr_pat    = wr && (bus.s_address >= ADDR_PATTERN_BASE);
  assign run_bit   = bus.s_writedata[CTRL_RUN];
  assign busy      = (state != ST_IDLE);
  assign abort     = wr_ctrl && !run_bit && busy;

  // A zero period still needs one wait cycle, so load max(period,1)-1.
  led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .en         (state == ST_WAIT),
    .load_value ((period == '0) ? '0 : period - PERIOD_W'(1)),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    idx_next   = idx;
    tmr_load   = 1'b0;
    done_set   = 1'b0;
    m_cs       = 1'b0;
    m_wn       = 1'b1;
    m_wd       = '0;
    case (state)
      ST_IDLE: begin
        if (wr_ctrl && run_bit) begin
          idx_next   = 2'd0;
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else begin
          m_cs       = 1'b1;
          m_wn       = 1'b0;
          m_wd       = 32'(pattern[idx]);
          tmr_load   = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (tmr_zero) begin
          if (idx != ctrl_last) begin
            idx_next   = idx + 2'd1;
            next_state = ST_WRITE;
          end else if (ctrl_loop) begin
            idx_next   = 2'd0;
            next_state = ST_WRITE;
          end else begin
            next_state = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        done_set   = !abort;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= 2'd0;
      ctrl_loop <= 1'b0;
      ctrl_last <= 2'd0;
      period    <= DEFAULT_PERIOD;
      done      <= 1'b0;
      for (int i = 0; i < 4; i++) pattern[i] <= '0;
    end else begin
      idx <= idx_next;
      if (wr_ctrl) begin
        ctrl_loop <= bus.s_writedata[CTRL_LOOP];
        ctrl_last <= bus.s_writedata[CTRL_LAST_LSB +: 2];
      end
      if (wr_period) period <= bus.s_writedata[PERIOD_W-1:0];
      if (wr_pat) pattern[bus.s_address[1:0]] <= bus.s_writedata[LED_W-1:0];
      // FINISH setting DONE beats a same-cycle software clear.
      if (done_set) begin
        done <= 1'b1;
      end else if (state == ST_IDLE && wr_ctrl && run_bit) begin
        done <= 1'b0;
      end else if (wr_status && bus.s_writedata[STAT_DONE]) begin
        done <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.s_address)
      ADDR_CTRL: begin
        rdata[CTRL_RUN]              = busy;
        rdata[CTRL_LOOP]             = ctrl_loop;
        rdata[CTRL_LAST_LSB +: 2]    = ctrl_last;
      end
      ADDR_PERIOD: rdata = 32'(period);
      ADDR_STATUS: begin
        rdata[STAT_BUSY]             = busy;
        rdata[STAT_IDX_LSB +: 2]     = idx;
        rdata[STAT_DONE]             = done;
      end
      3'd4, 3'd5, 3'd6, 3'd7: rdata = 32'(pattern[bus.s_address[1:0]]);
      default: rdata = '0;
    endcase
  end

  assign bus.s_readdata   = rdata;
  assign bus.m_address    = PIO_DATA_OFFSET;
  assign bus.m_chipselect = m_cs;
  assign bus.m_write_n    = m_wn;
  assign bus.m_writedata  = m_wd;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - randomized and directed checks of the LED pattern sequencer
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_seq_if bus ();

  led_pattern_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every PIO write pulse seen on the master side, with the cycle it occurred in.
  logic [31:0] mon_d[$];
  int          mon_c[$];
  always @(negedge clk) begin
    if (bus.m_chipselect === 1'b1 && bus.m_write_n === 1'b0) begin
      mon_d.push_back(bus.m_writedata);
      mon_c.push_back(cyc);
    end
  end

  logic [9:0]  pats [4];
  logic [31:0] exp_d [64];
  int          exp_c [64];
  int          exp_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.s_address    = a;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b0;
    bus.s_writedata  = d;
    @(posedge clk);
    #1;
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.s_address = a;
    #1;
    d = bus.s_readdata;
  endtask

  task automatic load_patterns();
    for (int k = 0; k < 4; k++) wr(ADDR_PATTERN_BASE + 3'(k), 32'(pats[k]));
  endtask

  // A single run visits patterns 0..last, one write every max(period,1)+1 cycles.
  task automatic model_run(input int last, input int period, input int c0);
    int gap;
    gap = ((period < 1) ? 1 : period) + 1;
    exp_n = last + 1;
    for (int k = 0; k <= last; k++) begin
      exp_d[k] = 32'(pats[k]);
      exp_c[k] = c0 + k * gap;
    end
  endtask

  // A looping run cycles through 0..last; only writes before cycle cnow are expected so far.
  task automatic model_loop(input int last, input int period, input int c0, input int cnow);
    int gap;
    gap = ((period < 1) ? 1 : period) + 1;
    exp_n = 0;
    while (c0 + exp_n * gap < cnow && exp_n < 64) begin
      exp_d[exp_n] = 32'(pats[exp_n % (last + 1)]);
      exp_c[exp_n] = c0 + exp_n * gap;
      exp_n++;
    end
  endtask

  task automatic compare_writes(input string tag);
    check($sformatf("%s_count", tag), 32'(mon_d.size()), 32'(exp_n));
    for (int k = 0; k < exp_n && k < mon_d.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), mon_d[k], exp_d[k]);
      check($sformatf("%s_cycle%0d", tag, k), 32'(mon_c[k]), 32'(exp_c[k]));
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    logic [31:0] s;
    rd(ADDR_STATUS, s);
    for (int i = 0; i < max_cyc && s[0] !== 1'b0; i++) begin
      step(1);
      rd(ADDR_STATUS, s);
    end
    check({tag, "_finished"}, 32'(s[0]), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int c0, n0, last, period;
    bit seen0, seen1;

    bus.s_address    = 3'd0;
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
    bus.s_writedata  = '0;
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);

    rd(ADDR_PERIOD, r);  check("rst_period", r, 32'd50000000);
    rd(ADDR_STATUS, r);  check("rst_status", r, 32'd0);
    rd(ADDR_CTRL, r);    check("rst_ctrl", r, 32'd0);
    check("rst_m_write_n", 32'(bus.m_write_n), 32'd1);
    check("rst_m_cs", 32'(bus.m_chipselect), 32'd0);
    check("rst_m_wdata", bus.m_writedata, 32'd0);
    check("rst_m_addr", 32'(bus.m_address), 32'd0);

    // Four-step single run.
    pats[0] = 10'h001; pats[1] = 10'h002; pats[2] = 10'h004; pats[3] = 10'h3FF;
    load_patterns();
    wr(ADDR_PERIOD, 32'd3);
    mon_d.delete(); mon_c.delete();
    wr(ADDR_CTRL, 32'h31);
    c0 = cyc;
    model_run(3, 3, c0);
    wait_idle("basic", 200);
    step(10);
    compare_writes("basic");
    rd(ADDR_STATUS, r);  check("basic_status", r, 32'h130);

    // Looping run with PERIOD=0.
    wr(ADDR_PERIOD, 32'd0);
    mon_d.delete(); mon_c.delete();
    wr(ADDR_CTRL, 32'h13);
    c0 = cyc;
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 6; i++) begin
      rd(ADDR_STATUS, r);
      check($sformatf("loop_busy%0d", i), 32'(r[0]), 32'd1);
      if (r[5:4] == 2'd0) seen0 = 1;
      if (r[5:4] == 2'd1) seen1 = 1;
      step(1);
    end
    check("loop_idx_toggles", 32'(seen0 && seen1), 32'd1);
    model_loop(1, 0, c0, cyc);
    compare_writes("loop");

    // Abort landing exactly on a WRITE cycle.
    for (int i = 0; i < 10 && bus.m_chipselect !== 1'b1; i++) step(1);
    check("abort_aligned", 32'(bus.m_chipselect), 32'd1);
    n0 = mon_d.size();
    bus.s_address    = ADDR_CTRL;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b0;
    bus.s_writedata  = 32'h0;
    #1;
    check("abort_suppress_cs", 32'(bus.m_chipselect), 32'd0);
    check("abort_suppress_wn", 32'(bus.m_write_n), 32'd1);
    @(posedge clk);
    #1;
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
    rd(ADDR_STATUS, r);
    check("abort_busy", 32'(r[0]), 32'd0);
    check("abort_done", 32'(r[8]), 32'd0);
    step(10);
    check("abort_no_writes", 32'(mon_d.size()), 32'(n0));

    // Pattern and period changed mid-run.
    wr(ADDR_PERIOD, 32'd2);
    mon_d.delete(); mon_c.delete();
    wr(ADDR_CTRL, 32'h31);
    c0 = cyc;
    wr(ADDR_PATTERN_BASE + 3'd2, 32'h155);
    wr(ADDR_PERIOD, 32'd10);
    pats[2] = 10'h155;
    exp_n = 4;
    for (int k = 0; k < 4; k++) begin
      exp_d[k] = 32'(pats[k]);
      // Write 0 loaded the old period of 2; later loads see 10.
      exp_c[k] = (k == 0) ? c0 : exp_c[k-1] + ((k == 1) ? 3 : 11);
    end
    wait_idle("midrun", 300);
    compare_writes("midrun");

    // DONE clear colliding with FINISH: set must win.
    wr(ADDR_PERIOD, 32'd0);
    wr(ADDR_CTRL, 32'h01);
    check("race_write", 32'(bus.m_chipselect), 32'd1);
    step(2);
    wr(ADDR_STATUS, 32'h100);
    rd(ADDR_STATUS, r);  check("race_done_set_wins", r, 32'h100);
    wr(ADDR_STATUS, 32'h100);
    rd(ADDR_STATUS, r);  check("race_done_cleared", r, 32'h000);

    // Randomized single runs against the model.
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 4; k++) pats[k] = 10'($urandom);
      period = int'($urandom_range(0, 4));
      last   = int'($urandom_range(0, 3));
      load_patterns();
      wr(ADDR_PERIOD, 32'(period));
      mon_d.delete(); mon_c.delete();
      wr(ADDR_CTRL, 32'((last << 4) | 1));
      c0 = cyc;
      model_run(last, period, c0);
      wait_idle($sformatf("rand%0d", it), 200);
      step(4);
      compare_writes($sformatf("rand%0d", it));
      rd(ADDR_STATUS, r);
      check($sformatf("rand%0d_status", it), r, 32'(32'h100 | (last << 4)));
    end

    // Asynchronous reset in the middle of a WAIT.
    wr(ADDR_PERIOD, 32'd20);
    wr(ADDR_CTRL, 32'h31);
    step(3);
    reset_n = 1'b0;
    #1;
    check("arst_m_cs", 32'(bus.m_chipselect), 32'd0);
    check("arst_m_write_n", 32'(bus.m_write_n), 32'd1);
    check("arst_m_wdata", bus.m_writedata, 32'd0);
    rd(ADDR_STATUS, r);  check("arst_status", r, 32'd0);
    rd(ADDR_PERIOD, r);  check("arst_period", r, 32'd50000000);
    rd(ADDR_CTRL, r);    check("arst_ctrl", r, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
